// File: rtl/alu_sched_pkg.sv
// Shared encodings for the ALU operation scheduler: FSM states, unit-select
// codes and the unit-enable decode.
package alu_sched_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam logic [1:0] SEL_ARITH = 2'b00;
  localparam logic [1:0] SEL_LOGIC = 2'b01;
  localparam logic [1:0] SEL_CMP   = 2'b10;
  localparam logic [1:0] SEL_SHIFT = 2'b11;

  // Bit order of the returned vector is {shift, cmp, logic, arith}.
  function automatic logic [3:0] sel_onehot(input logic [1:0] sel);
    return 4'b0001 << sel;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the last-grant register only advances when the
// caller signals that the current grant was actually taken.
module rr_arb2 (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] req,
  input  logic       update_en,
  output logic [1:0] gnt
);

  logic last_one;  // 1: requester 1 was granted last

  always_comb begin
    gnt[0] = req[0] & (~req[1] | last_one);
    gnt[1] = req[1] & (~req[0] | ~last_one);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)
      last_one <= 1'b1;
    else if (update_en)
      last_one <= gnt[1];
  end

endmodule

// File: rtl/alu_op_sched.sv
// Shares the arith/logic/cmp/shift units between two requesters: arbitrate,
// latch operands, pulse one unit enable, capture its result, hand it back.
module alu_op_sched
  import alu_sched_pkg::*;
#(
  parameter int DATA_WD = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               REQ0_VALID,
  output logic               REQ0_READY,
  input  logic [DATA_WD-1:0] REQ0_A,
  input  logic [DATA_WD-1:0] REQ0_B,
  input  logic [3:0]         REQ0_FUN,
  input  logic               REQ1_VALID,
  output logic               REQ1_READY,
  input  logic [DATA_WD-1:0] REQ1_A,
  input  logic [DATA_WD-1:0] REQ1_B,
  input  logic [3:0]         REQ1_FUN,
  output logic [DATA_WD-1:0] A_OUT,
  output logic [DATA_WD-1:0] B_OUT,
  output logic [1:0]         FUN_OUT,
  output logic               ARITH_EN,
  output logic               LOGIC_EN,
  output logic               CMP_EN,
  output logic               SHIFT_EN,
  input  logic [DATA_WD-1:0] ARITH_RES,
  input  logic [DATA_WD-1:0] LOGIC_RES,
  input  logic [DATA_WD-1:0] CMP_RES,
  input  logic [DATA_WD-1:0] SHIFT_RES,
  input  logic               ARITH_FLAG,
  input  logic               LOGIC_FLAG,
  input  logic               CMP_FLAG,
  input  logic               SHIFT_FLAG,
  output logic [DATA_WD-1:0] RES_DATA,
  output logic               RES_ID,
  output logic               RES_ERR,
  output logic               RES_VALID,
  input  logic               RES_READY
);

  logic [1:0]         state;
  logic [1:0]         gnt;
  logic [1:0]         sel_q;
  logic               id_q;
  logic               accept;
  logic [DATA_WD-1:0] unit_res;
  logic               unit_flag;
  logic [3:0]         en_vec;

  rr_arb2 u_arb (
    .CLK       (CLK),
    .RST       (RST),
    .req       ({REQ1_VALID, REQ0_VALID}),
    .update_en (accept),
    .gnt       (gnt)
  );

  // A grant already implies VALID, so READY alone marks the handshake.
  assign REQ0_READY = RST & (state == IDLE) & gnt[0];
  assign REQ1_READY = RST & (state == IDLE) & gnt[1];
  assign accept     = REQ0_READY | REQ1_READY;

  assign en_vec = (state == ISSUE) ? sel_onehot(sel_q) : '0;
  assign {SHIFT_EN, CMP_EN, LOGIC_EN, ARITH_EN} = en_vec;

  assign RES_VALID = (state == RESP);
  assign RES_ID    = id_q;

  always_comb begin
    unit_res  = ARITH_RES;
    unit_flag = ARITH_FLAG;
    case (sel_q)
      SEL_LOGIC: begin unit_res = LOGIC_RES; unit_flag = LOGIC_FLAG; end
      SEL_CMP:   begin unit_res = CMP_RES;   unit_flag = CMP_FLAG;   end
      SEL_SHIFT: begin unit_res = SHIFT_RES; unit_flag = SHIFT_FLAG; end
      default:   begin unit_res = ARITH_RES; unit_flag = ARITH_FLAG; end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      A_OUT    <= '0;
      B_OUT    <= '0;
      FUN_OUT  <= '0;
      sel_q    <= '0;
      id_q     <= 1'b0;
      RES_DATA <= '0;
      RES_ERR  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          state <= ISSUE;
          id_q  <= gnt[1];
          if (gnt[1]) begin
            A_OUT   <= REQ1_A;
            B_OUT   <= REQ1_B;
            FUN_OUT <= REQ1_FUN[1:0];
            sel_q   <= REQ1_FUN[3:2];
          end else begin
            A_OUT   <= REQ0_A;
            B_OUT   <= REQ0_B;
            FUN_OUT <= REQ0_FUN[1:0];
            sel_q   <= REQ0_FUN[3:2];
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          RES_DATA <= unit_res;
          RES_ERR  <= ~unit_flag;
          state    <= RESP;
        end
        RESP: if (RES_READY) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
